// File: rtl/sqrt_unit_scheduler.sv
// Round-robin scheduler sharing one iterative square-root core among NUM_REQ requesters.
// Optional macro SQRT_ZERO_BYPASS_EN: zero radicands are answered directly without starting the core.
module sqrt_unit_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = 4,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_radicand,
  input  logic [NUM_REQ*ID_W-1:0]       req_id,
  output logic                          core_start,
  output logic [DATA_WIDTH-1:0]         core_radicand,
  input  logic                          core_done,
  input  logic [DATA_WIDTH-1:0]         core_result,
  input  logic [DATA_WIDTH-1:0]         core_remainder,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic [DATA_WIDTH-1:0]         rsp_remainder,
  output logic [ID_W-1:0]               rsp_id,
  output logic [SRC_W-1:0]              rsp_src,
  output logic                          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [SRC_W:0] NUM_REQ_W = (SRC_W + 1)'(NUM_REQ);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [SRC_W-1:0]        prio_r;
  logic [SRC_W-1:0]        prio_nxt_s;
  logic [SRC_W:0]          sum_s;
  logic [SRC_W-1:0]        cand_s;
  logic                    take_s;
  logic [SRC_W:0]          nxt_sum_s;
  logic                    grant_found_s;
  logic [SRC_W-1:0]        grant_idx_s;
  logic [DATA_WIDTH-1:0]   grant_rad_s;
  logic [ID_W-1:0]         grant_id_s;
  logic                    rsp_acc_s;
  logic                    grant_en_s;
  logic                    hs_s;
  logic                    zero_byp_s;
  logic [NUM_REQ-1:0]      req_ready_s;
  logic                    core_start_r;
  logic [DATA_WIDTH-1:0]   core_radicand_r;
  logic [ID_W-1:0]         tag_r;
  logic [SRC_W-1:0]        src_r;
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_result_r;
  logic [DATA_WIDTH-1:0]   rsp_remainder_r;
  logic [ID_W-1:0]         rsp_id_r;
  logic [SRC_W-1:0]        rsp_src_r;
  logic                    busy_r;

  // Round-robin search for the first valid requester starting at the priority pointer
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {SRC_W{1'b0}};
    sum_s         = {(SRC_W + 1){1'b0}};
    cand_s        = {SRC_W{1'b0}};
    take_s        = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s         = {1'b0, prio_r} + (SRC_W + 1)'(i);
      cand_s        = SRC_W'((sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s);
      take_s        = !grant_found_s && req_valid[cand_s];
      grant_idx_s   = take_s ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | take_s;
    end
  end

  assign grant_rad_s = req_radicand[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id_s  = req_id[grant_idx_s*ID_W +: ID_W];
  assign nxt_sum_s   = {1'b0, grant_idx_s} + {{SRC_W{1'b0}}, 1'b1};
  assign prio_nxt_s  = SRC_W'((nxt_sum_s >= NUM_REQ_W) ? (nxt_sum_s - NUM_REQ_W) : nxt_sum_s);

  // A new grant is possible when idle, or in the same cycle the held response is accepted
  assign rsp_acc_s  = (state_r == ST_RESP) && rsp_ready;
  assign grant_en_s = (state_r == ST_IDLE) || rsp_acc_s;
  assign hs_s       = grant_en_s && grant_found_s;

`ifdef SQRT_ZERO_BYPASS_EN
  assign zero_byp_s = hs_s && (grant_rad_s == {DATA_WIDTH{1'b0}});
`else
  assign zero_byp_s = 1'b0;
`endif

  // One-hot grant, only while the block can take a new operation
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    req_ready_s[grant_idx_s] = hs_s;
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_nxt_s = zero_byp_s ? ST_RESP : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RESP: begin
        if (rsp_ready && hs_s) begin
          state_nxt_s = zero_byp_s ? ST_RESP : ST_RUN;
        end else if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register and registered busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Arbitration pointer, core launch and in-flight tag/source
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r          <= {SRC_W{1'b0}};
      core_start_r    <= 1'b0;
      core_radicand_r <= {DATA_WIDTH{1'b0}};
      tag_r           <= {ID_W{1'b0}};
      src_r           <= {SRC_W{1'b0}};
    end else begin
      core_start_r <= hs_s && !zero_byp_s;
      if (hs_s) begin
        prio_r <= prio_nxt_s;
        tag_r  <= grant_id_s;
        src_r  <= grant_idx_s;
      end
      if (hs_s && !zero_byp_s) begin
        core_radicand_r <= grant_rad_s;
      end
    end
  end

  // One-entry response register; core_done only counts while an operation is running
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r     <= 1'b0;
      rsp_result_r    <= {DATA_WIDTH{1'b0}};
      rsp_remainder_r <= {DATA_WIDTH{1'b0}};
      rsp_id_r        <= {ID_W{1'b0}};
      rsp_src_r       <= {SRC_W{1'b0}};
    end else if ((state_r == ST_RUN) && core_done) begin
      rsp_valid_r     <= 1'b1;
      rsp_result_r    <= core_result;
      rsp_remainder_r <= core_remainder;
      rsp_id_r        <= tag_r;
      rsp_src_r       <= src_r;
    end else if (zero_byp_s) begin
      rsp_valid_r     <= 1'b1;
      rsp_result_r    <= {DATA_WIDTH{1'b0}};
      rsp_remainder_r <= {DATA_WIDTH{1'b0}};
      rsp_id_r        <= grant_id_s;
      rsp_src_r       <= grant_idx_s;
    end else if (rsp_acc_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign req_ready     = req_ready_s;
  assign core_start    = core_start_r;
  assign core_radicand = core_radicand_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_result    = rsp_result_r;
  assign rsp_remainder = rsp_remainder_r;
  assign rsp_id        = rsp_id_r;
  assign rsp_src       = rsp_src_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_sqrt_unit_scheduler.sv
// Bench for sqrt_unit_scheduler: stub core (5-cycle latency, result=~x, remainder=x), directed
// steps followed by randomized traffic, all checked against a transaction-level reference model.
module tb_sqrt_unit_scheduler;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int IW = 4;
  localparam int SW = 1;
`ifdef SQRT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_radicand;
  logic [NR*IW-1:0]  req_id;
  logic              core_start;
  logic [DW-1:0]     core_radicand;
  logic              core_done;
  logic [DW-1:0]     core_result;
  logic [DW-1:0]     core_remainder;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_result;
  logic [DW-1:0]     rsp_remainder;
  logic [IW-1:0]     rsp_id;
  logic [SW-1:0]     rsp_src;
  logic              busy;

  logic [DW-1:0]     rad_a [NR];
  logic [IW-1:0]     id_a  [NR];

  sqrt_unit_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_radicand(req_radicand), .req_id(req_id),
    .core_start(core_start), .core_radicand(core_radicand),
    .core_done(core_done), .core_result(core_result), .core_remainder(core_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_remainder(rsp_remainder),
    .rsp_id(rsp_id), .rsp_src(rsp_src), .busy(busy)
  );

  always_comb begin
    req_radicand = '0;
    req_id       = '0;
    for (int r = 0; r < NR; r++) begin
      req_radicand[r*DW +: DW] = rad_a[r];
      req_id[r*IW +: IW]       = id_a[r];
    end
  end

  // Stub core: done pulse a fixed number of cycles after start
  int          stub_cnt;
  logic [DW-1:0] stub_rad;
  logic        stub_done;
  logic        spur_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_rad  <= '0;
    end else begin
      stub_done <= (stub_cnt == 1);
      if (core_start) begin
        stub_cnt <= 5;
        stub_rad <= core_radicand;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end
  assign core_done      = stub_done | spur_done;
  assign core_result    = ~stub_rad;
  assign core_remainder = stub_rad;

  // Reference model: one operation in flight, one held response, rotating priority pointer
  int            checks, errors;
  bit            m_run, m_resp, exp_start;
  int            ptr;
  logic [DW-1:0] exp_rad, p_res, p_rem, e_res, e_rem;
  logic [IW-1:0] p_id, e_id;
  int            p_src, e_src;
  logic [NR-1:0] hs_mask;
  bit            rec_grants;
  int            grants[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_rr(input logic [NR-1:0] v, input int p);
    int j;
    for (int k = 0; k < NR; k++) begin
      j = (p + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic cyc();
    logic [NR-1:0] exp_ready;
    int pick;
    bit allowed;
    @(negedge clk);
    hs_mask = '0;
    if (rst) begin
      m_run = 0; m_resp = 0; ptr = 0; exp_start = 0;
    end else begin
      check("rsp_valid", rsp_valid, m_resp);
      check("busy", busy, m_run | m_resp);
      check("core_start", core_start, exp_start);
      if (exp_start) check("core_radicand", core_radicand, exp_rad);
      if (m_resp) begin
        check("rsp_result", rsp_result, e_res);
        check("rsp_remainder", rsp_remainder, e_rem);
        check("rsp_id", rsp_id, e_id);
        check("rsp_src", rsp_src, e_src);
      end
      allowed = !m_run && (!m_resp || rsp_ready);
      pick = allowed ? pick_rr(req_valid, ptr) : -1;
      exp_ready = '0;
      if (pick >= 0) exp_ready[pick] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      if (rec_grants) begin
        for (int r = 0; r < NR; r++) if (req_ready[r]) grants.push_back(r);
      end
      exp_start = 0;
      if (m_run && core_done) begin
        m_run = 0; m_resp = 1;
        e_res = p_res; e_rem = p_rem; e_id = p_id; e_src = p_src;
      end else if (m_resp && rsp_ready) begin
        m_resp = 0;
      end
      if (pick >= 0) begin
        hs_mask[pick] = 1'b1;
        ptr = (pick + 1) % NR;
        if (BYP && rad_a[pick] == '0) begin
          m_resp = 1; e_res = '0; e_rem = '0; e_id = id_a[pick]; e_src = pick;
        end else begin
          m_run = 1; exp_start = 1; exp_rad = rad_a[pick];
          p_res = ~rad_a[pick]; p_rem = rad_a[pick]; p_id = id_a[pick]; p_src = pick;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 40 && !rsp_valid; n++) cyc();
    check("wait_rsp_timeout", rsp_valid, 1'b1);
  endtask

  task automatic refresh();
    for (int r = 0; r < NR; r++) begin
      if (hs_mask[r] || !req_valid[r]) begin
        rad_a[r] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        id_a[r]  = IW'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_core_start"}, core_start, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_rsp_result"}, rsp_result, 32'h0);
    check({tag, "_rsp_remainder"}, rsp_remainder, 32'h0);
    check({tag, "_rsp_id"}, rsp_id, 4'h0);
    check({tag, "_rsp_src"}, rsp_src, 1'b0);
  endtask

  initial begin
    int idle_cnt;
    checks = 0; errors = 0;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; spur_done = 1'b0;
    m_run = 0; m_resp = 0; ptr = 0; exp_start = 0; hs_mask = '0; rec_grants = 0;
    for (int r = 0; r < NR; r++) begin rad_a[r] = '0; id_a[r] = '0; end
    @(posedge clk); #1;
    repeat (3) cyc();
    rst = 1'b0;
    check_reset_outputs("reset");

    // 1: single request from requester 0
    rad_a[0] = 32'h0000_0090; id_a[0] = 4'd3; req_valid = 2'b01;
    cyc();
    check("t1_start", core_start, 1'b1);
    check("t1_rad", core_radicand, 32'h0000_0090);
    req_valid = 2'b00;
    wait_rsp();
    check("t1_result", rsp_result, 32'hFFFF_FF6F);
    check("t1_remainder", rsp_remainder, 32'h0000_0090);
    check("t1_id", rsp_id, 4'd3);
    check("t1_src", rsp_src, 1'b0);
    rsp_ready = 1'b1;
    cyc();
    check("t1_drop", rsp_valid, 1'b0);

    // 2: both requesting continuously, alternating grants with no bubble
    req_valid = 2'b11; rec_grants = 1; grants.delete(); idle_cnt = 0;
    for (int n = 0; n < 200 && grants.size() < 4; n++) begin
      refresh();
      cyc();
      if (grants.size() > 0 && !busy) idle_cnt++;
    end
    rec_grants = 0;
    check("t2_ngrants", grants.size(), 4);
    for (int k = 0; k < grants.size(); k++) check("t2_order", grants[k], (k + 1) % 2);
    check("t2_idle", idle_cnt, 0);
    req_valid = 2'b00;
    repeat (20) cyc();

    // 3: consumer stalls the response for 10 cycles while requests are pending
    rsp_ready = 1'b0; rad_a[1] = 32'hDEAD_BEEF; id_a[1] = 4'd9; req_valid = 2'b10;
    cyc();
    req_valid = 2'b11;
    wait_rsp();
    repeat (10) cyc();
    check("t3_held", rsp_valid, 1'b1);
    check("t3_id", rsp_id, 4'd9);
    req_valid = 2'b00; rsp_ready = 1'b1;
    cyc();
    check("t3_drop", rsp_valid, 1'b0);
    rsp_ready = 1'b0;
    repeat (3) cyc();

    // 4: spurious done while idle, then reset two cycles into a run
    spur_done = 1'b1;
    cyc();
    spur_done = 1'b0;
    cyc();
    check("t4_spur_valid", rsp_valid, 1'b0);
    check("t4_spur_busy", busy, 1'b0);
    rad_a[0] = 32'h0000_1234; id_a[0] = 4'd5; req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_outputs("t4_abort");
    repeat (10) cyc();
    check("t4_no_rsp", rsp_valid, 1'b0);

    // 5: zero radicand
    rad_a[0] = 32'h0; id_a[0] = 4'd7; req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    check("t5_start", core_start, !BYP);
    check("t5_early_valid", rsp_valid, BYP);
    wait_rsp();
    check("t5_result", rsp_result, BYP ? 32'h0 : 32'hFFFF_FFFF);
    check("t5_remainder", rsp_remainder, 32'h0);
    check("t5_id", rsp_id, 4'd7);
    rsp_ready = 1'b1;
    cyc();

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      refresh();
      for (int r = 0; r < NR; r++) req_valid[r] = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (20) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
